// File: rtl/multicycle_seq32_pkg.sv
// multicycle_seq32_pkg: state encoding, pc_src codes, opcode constants and instruction classes
package multicycle_seq32_pkg;
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    FAULT  = 3'd5
  } state_t;
  localparam logic [1:0] PC_SEQ  = 2'd0;
  localparam logic [1:0] PC_BR   = 2'd1;
  localparam logic [1:0] PC_JUMP = 2'd2;
  localparam logic [1:0] PC_JR   = 2'd3;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  typedef enum logic [3:0] {
    CL_RALU, CL_JR, CL_I, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_ILL
  } iclass_t;
endpackage

// File: rtl/multicycle_seq32_instr_class32.sv
// instr_class32: combinational MIPS32 opcode/funct to instruction-class decoder
module instr_class32
  import multicycle_seq32_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass
);
  always_comb begin
    iclass = opcode == OP_RTYPE    ? (funct == FN_JR ? CL_JR : CL_RALU) :
             opcode[5:3] == 3'b001 ? CL_I   :
             opcode == OP_LW       ? CL_LW  :
             opcode == OP_SW       ? CL_SW  :
             opcode == OP_BEQ      ? CL_BEQ :
             opcode == OP_BNE      ? CL_BNE :
             opcode == OP_J        ? CL_J   :
             opcode == OP_JAL      ? CL_JAL : CL_ILL;
  end
endmodule

// File: rtl/multicycle_seq32.sv
// multicycle_seq32: MIPS32 multi-cycle sequencer with memory handshakes, watchdog and retire counter
module multicycle_seq32
  import multicycle_seq32_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Function_opcode,
  input  logic             Zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             illegal,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);
  state_t      st;
  iclass_t     cls;
  logic [31:0] wait_cnt;
  logic        run;
  logic        taken;
  logic        ctl_xfer;
  logic        timeout_hit;
  instr_class32 u_class (
    .opcode (Opcode),
    .funct  (Function_opcode),
    .iclass (cls)
  );
  always_comb begin
    run         = ~reset;
    taken       = (cls == CL_BEQ && Zero) || (cls == CL_BNE && !Zero);
    ctl_xfer    = cls inside {CL_BEQ, CL_BNE, CL_J, CL_JR};
    timeout_hit = TIMEOUT != 0 && wait_cnt == 32'(TIMEOUT - 1);
    imem_req    = run && st == FETCH;
    ir_write    = imem_req && imem_ack;
    dmem_req    = run && st == MEM;
    dmem_we     = dmem_req && cls == CL_SW;
    reg_write   = run && st == WB;
    illegal     = run && st == DECODE && cls == CL_ILL;
    fault       = run && st == FAULT;
    pc_write    = illegal || (run && st == EXEC && ctl_xfer) || (dmem_we && dmem_ack) || reg_write;
    pc_src      = !pc_write ? PC_SEQ :
                  st == EXEC ? (cls == CL_J ? PC_JUMP : cls == CL_JR ? PC_JR : taken ? PC_BR : PC_SEQ) :
                  st == WB && cls == CL_JAL ? PC_JUMP : PC_SEQ;
    state       = st;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st       <= FETCH;
      wait_cnt <= '0;
      instret  <= '0;
    end else begin
      wait_cnt <= '0;
      if (pc_write) instret <= instret + CNT_W'(1);
      case (st)
        FETCH:   if (imem_ack) st <= DECODE;
                 else if (timeout_hit) st <= FAULT;
                 else wait_cnt <= wait_cnt + 32'd1;
        DECODE:  st <= cls == CL_ILL ? FETCH : EXEC;
        EXEC:    st <= ctl_xfer ? FETCH : cls inside {CL_LW, CL_SW} ? MEM : WB;
        MEM:     if (dmem_ack) st <= cls == CL_SW ? FETCH : WB;
                 else if (timeout_hit) st <= FAULT;
                 else wait_cnt <= wait_cnt + 32'd1;
        WB:      st <= FETCH;
        FAULT:   st <= FAULT;
        default: st <= FAULT;
      endcase
    end
  end
endmodule
